audio_peak_limiter: RTL and testbench

Sample-rate peak limiter that consumes the DC-blocked output of `resistor_capacitor_high_pass_filter` and bounds it before it reaches the board mixer. It tracks overload with an attack/hold/release gain state machine and applies a 17-bit gain to each sample. A final hard clip guarantees the output never exceeds the threshold. All state updates only on `audio_clk_en` strobes.

---
 rtl/audio_peak_limiter.sv | 125 ++++++++++++
 tb/tb_audio_peak_limiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/audio_peak_limiter.sv
// Sample-rate peak limiter. It tracks overload with an attack/hold/release gain FSM and hard-clips the output to +/-THRESHOLD.
// Output is registered on the same audio_clk_en edge that samples `in`. There is no backpressure: without a strobe, every register holds.
`timescale 1ns/1ps
module audio_peak_limiter #(
  parameter int THRESHOLD     = 24576,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8,
  parameter int HOLD_SAMPLES  = 480,
  parameter int MIN_GAIN      = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic signed [15:0] out,
  output logic [16:0]        gain,
  output logic               limiting
);

  localparam int CW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam logic [16:0]        UNITY     = 17'd65536;
  localparam logic [16:0]        FLOOR     = 17'(MIN_GAIN);
  localparam logic [16:0]        THR       = 17'(THRESHOLD);
  localparam logic signed [17:0] THR_POS   = 18'(THRESHOLD);
  localparam logic signed [17:0] THR_NEG   = -THR_POS;
  localparam logic [CW-1:0]      HOLD_LOAD = CW'(HOLD_SAMPLES);

  typedef enum logic [1:0] {IDLE, ATTACK, HOLD, RELEASE} state_t;

  state_t             state;
  logic [CW-1:0]      hold_cnt;

  logic [15:0]        mag;
  logic [16:0]        pred;
  logic               over;
  logic signed [17:0] sgain;
  logic signed [17:0] y;
  logic signed [15:0] out_nxt;
  logic [16:0]        a_step;
  logic [16:0]        a_diff;
  logic [16:0]        g_att;
  logic [16:0]        r_step;
  logic [17:0]        r_sum;
  logic [16:0]        g_rel;

  always_comb begin
    // -32768 has no positive twin in 16 bits, so its magnitude saturates.
    mag = in;
    if (in[15]) mag = (in == -16'sd32768) ? 16'd32767 : 16'(-in);
    pred  = 17'((33'(mag) * 33'(gain)) >> 16);
    over  = (pred > THR);
    sgain = $signed({1'b0, gain});
    y     = 18'((34'(in) * 34'(sgain)) >>> 16);

    out_nxt = 16'(y);
    if (y > THR_POS)      out_nxt = 16'(THR_POS);
    else if (y < THR_NEG) out_nxt = 16'(THR_NEG);

    a_step = gain >> ATTACK_SHIFT;
    if (a_step == 17'd0) a_step = 17'd1;
    a_diff = gain - a_step;
    g_att  = (a_diff < FLOOR) ? FLOOR : a_diff;

    r_step = (UNITY - gain) >> RELEASE_SHIFT;
    if (r_step == 17'd0) r_step = 17'd1;
    r_sum = {1'b0, gain} + {1'b0, r_step};
    g_rel = (r_sum > {1'b0, UNITY}) ? UNITY : r_sum[16:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gain     <= UNITY;
      hold_cnt <= '0;
      out      <= '0;
      limiting <= 1'b0;
    end else if (audio_clk_en) begin
      out <= out_nxt;
      case (state)
        IDLE: begin
          if (over) begin
            gain     <= g_att;
            state    <= ATTACK;
            limiting <= 1'b1;
          end
        end
        ATTACK: begin
          if (over) begin
            gain <= g_att;
          end else begin
            hold_cnt <= HOLD_LOAD;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (over) begin
            gain  <= g_att;
            state <= ATTACK;
          end else if (hold_cnt == '0) begin
            state <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt - CW'(1);
          end
        end
        RELEASE: begin
          if (over) begin
            gain  <= g_att;
            state <= ATTACK;
          end else begin
            gain <= g_rel;
            if (g_rel == UNITY) begin
              state    <= IDLE;
              limiting <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          limiting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_peak_limiter.sv
// Directed bench for audio_peak_limiter: a default instance plus a low-threshold, high-floor instance for gain-floor cases.
`timescale 1ns/1ps
module tb_audio_peak_limiter;

  logic               clk;
  logic               reset_n;
  logic               audio_clk_en;
  logic signed [15:0] in;
  logic signed [15:0] out_a;
  logic [16:0]        gain_a;
  logic               lim_a;
  logic signed [15:0] out_b;
  logic [16:0]        gain_b;
  logic               lim_b;

  int checks = 0;
  int errors = 0;

  audio_peak_limiter u_dut (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(audio_clk_en), .in(in),
    .out(out_a), .gain(gain_a), .limiting(lim_a)
  );

  audio_peak_limiter #(.THRESHOLD(8192), .MIN_GAIN(40000)) u_floor (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(audio_clk_en), .in(in),
    .out(out_b), .gain(gain_b), .limiting(lim_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic strobe();
    @(negedge clk);
    audio_clk_en = 1'b1;
    @(posedge clk);
    #1;
    audio_clk_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic signed [15:0] sv_out_a, sv_out_b;
    logic [16:0]        sv_gain_a, sv_gain_b;
    int n;

    reset_n      = 1'b0;
    audio_clk_en = 1'b1;
    in           = 16'sd32767;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out_a, 0);
    check("rst_gain", gain_a, 65536);
    check("rst_lim", lim_a, 0);
    check("rst_gain_b", gain_b, 65536);
    audio_clk_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    in = 16'sd10000;
    for (int i = 0; i < 100; i++) begin
      strobe();
      check("pass_out", out_a, 10000);
    end
    check("pass_gain", gain_a, 65536);
    check("pass_lim", lim_a, 0);

    in = 16'sd32767;
    strobe();
    check("atk1_out", out_a, 24576);
    check("atk1_gain", gain_a, 49152);
    check("atk1_lim", lim_a, 1);
    strobe();
    check("atk2_out", out_a, 24575);
    check("atk2_gain", gain_a, 49152);
    check("atk2_lim", lim_a, 1);

    in = 16'sd1000;
    for (int i = 0; i < 481; i++) begin
      strobe();
      check("hold_out", out_a, 750);
      check("hold_gain", gain_a, 49152);
    end
    check("hold_lim", lim_a, 1);
    strobe();
    check("rel1_gain", gain_a, 49216);
    check("rel1_out", out_a, 750);
    strobe();
    check("rel2_gain", gain_a, 49279);
    check("rel2_lim", lim_a, 1);
    n = 0;
    while (gain_a != 17'd65536 && n < 5000) begin
      strobe();
      n++;
    end
    check("rel_done_gain", gain_a, 65536);
    check("rel_done_lim", lim_a, 0);
    strobe();
    check("rel_after_out", out_a, 1000);
    check("rel_after_lim", lim_a, 0);

    pulse_reset();
    in = -16'sd32768;
    strobe();
    check("neg1_out", out_a, -24576);
    check("neg1_gain", gain_a, 49152);
    for (int i = 0; i < 5; i++) begin
      strobe();
      check("neg_bound", (out_a >= -16'sd24576) ? 1 : 0, 1);
    end

    pulse_reset();
    in = 16'sd32767;
    strobe();
    check("floor1_gain", gain_b, 49152);
    check("floor1_out", out_b, 8192);
    for (int i = 0; i < 9; i++) begin
      strobe();
      check("floor_gain", gain_b, 40000);
      check("floor_out", out_b, 8192);
      check("floor_lim", lim_b, 1);
    end

    sv_out_a  = out_a;
    sv_gain_a = gain_a;
    sv_out_b  = out_b;
    sv_gain_b = gain_b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in = 16'($urandom);
      @(posedge clk);
      #1;
      check("gate_out_a", out_a, sv_out_a);
      check("gate_gain_a", gain_a, sv_gain_a);
      check("gate_out_b", out_b, sv_out_b);
      check("gate_gain_b", gain_b, sv_gain_b);
    end

    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_out_b", out_b, 0);
    check("async_gain_b", gain_b, 65536);
    check("async_lim_b", lim_b, 0);
    check("async_lim_a", lim_a, 0);
    check("async_gain_a", gain_a, 65536);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
